// File: rtl/stopwatch_ctrl.sv
// Stopwatch command generator: button conditioning, run/pause/clear/load FSM, registered counter commands.
// Optional button debouncing is built when STOPWATCH_DEBOUNCE_EN is defined.
module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int MAX_COUNT       = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        btn_start,
    input  logic        btn_clear,
    input  logic        btn_load,
    input  logic        mode_down,
    input  logic [13:0] count,
    output logic [2:0]  cmd,
    output logic        running,
    output logic        paused,
    output logic        done
);

    // state      | meaning
    // S_IDLE     | stopped, accepts clear/load/start
    // S_RUN_UP   | counting up on each tick
    // S_RUN_DOWN | counting down on each tick
    // S_PAUSED   | frozen, remembers direction
    // S_DONE     | terminal count reached
    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN_UP,
        S_RUN_DOWN,
        S_PAUSED,
        S_DONE
    } state_t;

    localparam logic [2:0] CMD_HOLD   = 3'b000;
    localparam logic [2:0] CMD_INC    = 3'b001;
    localparam logic [2:0] CMD_DEC    = 3'b010;
    localparam logic [2:0] CMD_CLEAR  = 3'b011;
    localparam logic [2:0] CMD_PRESET = 3'b100;
    localparam logic [2:0] CMD_LOAD   = 3'b101;

    // Button vectors are ordered {load, clear, start}.
    logic [2:0] btn_raw;
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] btn_q;
    logic [2:0] btn_q_d;
    logic [2:0] press;

    assign btn_raw = {btn_load, btn_clear, btn_start};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

`ifdef STOPWATCH_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CW-1:0] db_cnt [3];

    // The qualified level follows only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_q <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == btn_q[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    btn_q[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    assign btn_q = sync2;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_q_d <= '0;
            press   <= '0;
        end else begin
            btn_q_d <= btn_q;
            press   <= btn_q & ~btn_q_d;
        end
    end

    logic p_start;
    logic p_clear;
    logic p_load;

    assign p_start = press[0];
    assign p_clear = press[1];
    assign p_load  = press[2];

    state_t     state;
    state_t     state_nx;
    logic       dir_up;
    logic       dir_up_nx;
    logic [2:0] cmd_nx;
    logic [2:0] clr_cmd;
    logic       at_max;
    logic       at_zero;

    assign clr_cmd = mode_down ? CMD_PRESET : CMD_CLEAR;
    assign at_max  = (count == 14'(MAX_COUNT));
    assign at_zero = (count == 14'd0);

    always_comb begin
        state_nx  = state;
        dir_up_nx = dir_up;
        cmd_nx    = CMD_HOLD;
        if (p_clear) begin
            cmd_nx   = clr_cmd;
            state_nx = S_IDLE;
        end else if (p_load) begin
            // Load is swallowed while running; it does not fall through to start.
            if (state != S_RUN_UP && state != S_RUN_DOWN) begin
                cmd_nx   = CMD_LOAD;
                state_nx = S_IDLE;
            end
        end else if (p_start) begin
            case (state)
                S_IDLE: begin
                    dir_up_nx = ~mode_down;
                    if (!mode_down)  state_nx = S_RUN_UP;
                    else if (at_zero) state_nx = S_DONE;
                    else             state_nx = S_RUN_DOWN;
                end
                S_RUN_UP, S_RUN_DOWN: state_nx = S_PAUSED;
                S_PAUSED:             state_nx = dir_up ? S_RUN_UP : S_RUN_DOWN;
                S_DONE:               state_nx = S_DONE;
                default:              state_nx = S_IDLE;
            endcase
        end else if (tick) begin
            case (state)
                S_RUN_UP: begin
                    if (at_max) state_nx = S_DONE;
                    else        cmd_nx   = CMD_INC;
                end
                S_RUN_DOWN: begin
                    if (at_zero) state_nx = S_DONE;
                    else         cmd_nx   = CMD_DEC;
                end
                S_IDLE, S_PAUSED, S_DONE: state_nx = state;
                default:                  state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            dir_up  <= 1'b0;
            cmd     <= CMD_HOLD;
            running <= 1'b0;
            paused  <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            dir_up  <= dir_up_nx;
            cmd     <= cmd_nx;
            running <= (state_nx == S_RUN_UP) || (state_nx == S_RUN_DOWN);
            paused  <= (state_nx == S_PAUSED);
            done    <= (state_nx == S_DONE);
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: vector table, directed corner sequences and random stimulus
// against a cycle-level behavioural model.
module tb_stopwatch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        btn_start;
    logic        btn_clear;
    logic        btn_load;
    logic        mode_down;
    logic [13:0] count;
    logic [2:0]  cmd;
    logic        running;
    logic        paused;
    logic        done;

    int errors = 0;
    int checks = 0;

    stopwatch_ctrl #(.DEBOUNCE_CYCLES(8), .MAX_COUNT(9999)) dut (
        .clk(clk), .rst(rst), .tick(tick), .btn_start(btn_start), .btn_clear(btn_clear),
        .btn_load(btn_load), .mode_down(mode_down), .count(count), .cmd(cmd),
        .running(running), .paused(paused), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk3(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk3({tag, ".cmd"}, cmd, 3'd0);
        chk1({tag, ".running"}, running, 1'b0);
        chk1({tag, ".paused"}, paused, 1'b0);
        chk1({tag, ".done"}, done, 1'b0);
    endtask

`ifdef STOPWATCH_DEBOUNCE_EN
    task automatic chkn(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_debounce();
        int n;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            btn_clear = ((c >= 2 && c < 5) || (c >= 15 && c < 18));
            @(posedge clk); #1;
            if (cmd == 3'd3) n++;
        end
        chkn("glitch_clear_count", n, 0);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            btn_clear = (c < 12);
            @(posedge clk); #1;
            if (cmd == 3'd3) n++;
        end
        chkn("held_clear_count", n, 1);
    endtask
`else
    // Behavioural model: one RUN state plus a remembered direction; presses appear three
    // edges after the raw level rises.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;
    int         m_state;
    logic       m_down;
    logic [2:0] m_cmd;
    logic [4:0] hs, hc, hl;

    task automatic mdl_reset();
        m_state = M_IDLE;
        m_down  = 1'b0;
        m_cmd   = 3'd0;
        hs = '0; hc = '0; hl = '0;
    endtask

    task automatic mdl_step(input logic bs, input logic bc, input logic bl, input logic tk,
                            input logic md, input logic [13:0] cnt);
        logic ps, pc, pl;
        hs = {hs[3:0], bs};
        hc = {hc[3:0], bc};
        hl = {hl[3:0], bl};
        ps = hs[3] & ~hs[4];
        pc = hc[3] & ~hc[4];
        pl = hl[3] & ~hl[4];
        m_cmd = 3'd0;
        if (pc) begin
            m_cmd   = md ? 3'd4 : 3'd3;
            m_state = M_IDLE;
        end else if (pl) begin
            if (m_state != M_RUN) begin
                m_cmd   = 3'd5;
                m_state = M_IDLE;
            end
        end else if (ps) begin
            if (m_state == M_IDLE) begin
                m_down  = md;
                m_state = (md && cnt == 0) ? M_DONE : M_RUN;
            end else if (m_state == M_RUN) begin
                m_state = M_PAUSED;
            end else if (m_state == M_PAUSED) begin
                m_state = M_RUN;
            end
        end else if (tk && m_state == M_RUN) begin
            if (!m_down) begin
                if (cnt == 14'd9999) m_state = M_DONE;
                else                 m_cmd   = 3'd1;
            end else begin
                if (cnt == 14'd0) m_state = M_DONE;
                else              m_cmd   = 3'd2;
            end
        end
    endtask

    task automatic step(input logic bs, input logic bc, input logic bl, input logic tk,
                        input logic md, input logic [13:0] cnt, input string tag);
        btn_start = bs; btn_clear = bc; btn_load = bl; tick = tk; mode_down = md; count = cnt;
        mdl_step(bs, bc, bl, tk, md, cnt);
        @(posedge clk); #1;
        chk3({tag, ".cmd"}, cmd, m_cmd);
        chk1({tag, ".running"}, running, m_state == M_RUN);
        chk1({tag, ".paused"}, paused, m_state == M_PAUSED);
        chk1({tag, ".done"}, done, m_state == M_DONE);
    endtask

    // which = {load, clear, start}; the press takes effect on the fourth step.
    task automatic press(input logic [2:0] which, input logic md, input logic [13:0] cnt,
                         input logic tk_last, input string tag);
        for (int i = 0; i < 4; i++)
            step(which[0] && i == 0, which[1] && i == 0, which[2] && i == 0,
                 tk_last && i == 3, md, cnt, tag);
    endtask

    typedef struct {
        logic        bs, bc, bl, tk, md;
        logic [13:0] cnt;
        logic [2:0]  e_cmd;
        logic        e_run, e_pau, e_done;
    } vec_t;

    function automatic vec_t mk(input int bs, input int bc, input int bl, input int tk,
                                input int cnt, input int ec, input int er, input int ed);
        vec_t v;
        v.bs = bs[0]; v.bc = bc[0]; v.bl = bl[0]; v.tk = tk[0]; v.md = 1'b0;
        v.cnt = 14'(cnt); v.e_cmd = 3'(ec);
        v.e_run = er[0]; v.e_pau = 1'b0; v.e_done = ed[0];
        return v;
    endfunction

    task automatic run_main();
        vec_t tbl [21];
        logic rs, rc, rl, md_r, tk;
        logic [13:0] cv;
        int last_tick;

        // Count up from start, INC pulses, terminal at 9999, start ignored in DONE, clear.
        tbl[0]  = mk(1, 0, 0, 0, 0,    0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0,    0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0,    0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0,    0, 1, 0);
        tbl[4]  = mk(0, 0, 0, 1, 0,    1, 1, 0);
        tbl[5]  = mk(0, 0, 0, 0, 1,    0, 1, 0);
        tbl[6]  = mk(0, 0, 0, 0, 1,    0, 1, 0);
        tbl[7]  = mk(0, 0, 0, 1, 1,    1, 1, 0);
        tbl[8]  = mk(0, 0, 0, 0, 2,    0, 1, 0);
        tbl[9]  = mk(0, 0, 0, 0, 2,    0, 1, 0);
        tbl[10] = mk(0, 0, 0, 1, 9999, 0, 0, 1);
        tbl[11] = mk(1, 0, 0, 0, 9999, 0, 0, 1);
        tbl[12] = mk(0, 0, 0, 0, 9999, 0, 0, 1);
        tbl[13] = mk(0, 0, 0, 0, 9999, 0, 0, 1);
        tbl[14] = mk(0, 0, 0, 0, 9999, 0, 0, 1);
        tbl[15] = mk(0, 0, 0, 1, 9999, 0, 0, 1);
        tbl[16] = mk(0, 1, 0, 0, 0,    0, 0, 1);
        tbl[17] = mk(0, 0, 0, 0, 0,    0, 0, 1);
        tbl[18] = mk(0, 0, 0, 0, 0,    0, 0, 1);
        tbl[19] = mk(0, 0, 0, 0, 0,    3, 0, 0);
        tbl[20] = mk(0, 0, 0, 0, 0,    0, 0, 0);

        for (int i = 0; i < 21; i++) begin
            step(tbl[i].bs, tbl[i].bc, tbl[i].bl, tbl[i].tk, tbl[i].md, tbl[i].cnt, "tbl");
            chk3($sformatf("vec%0d.cmd", i), cmd, tbl[i].e_cmd);
            chk1($sformatf("vec%0d.running", i), running, tbl[i].e_run);
            chk1($sformatf("vec%0d.paused", i), paused, tbl[i].e_pau);
            chk1($sformatf("vec%0d.done", i), done, tbl[i].e_done);
        end

        // Count down: PRESET on clear, DEC x3, terminal at zero.
        press(3'b010, 1'b1, 14'd3, 1'b0, "preset");
        chk3("preset_cmd", cmd, 3'd4);
        press(3'b001, 1'b1, 14'd3, 1'b0, "start_down");
        chk1("start_down_running", running, 1'b1);
        for (int v = 3; v >= 1; v--) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 14'(v), "down_tick");
            chk3("dec_cmd", cmd, 3'd2);
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 14'(v - 1), "down_gap");
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 14'(v - 1), "down_gap");
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 14'd0, "down_term");
        chk1("down_term_done", done, 1'b1);
        chk3("down_term_cmd", cmd, 3'd0);

        // Start + tick together pauses without INC; load from PAUSED.
        press(3'b010, 1'b0, 14'd0, 1'b0, "clear_up");
        chk3("clear_cmd", cmd, 3'd3);
        press(3'b001, 1'b0, 14'd0, 1'b0, "start_up");
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 14'd0, "up_tick");
        press(3'b001, 1'b0, 14'd1, 1'b1, "pause_tick");
        chk1("pause_tick_paused", paused, 1'b1);
        chk3("pause_tick_cmd", cmd, 3'd0);
        press(3'b100, 1'b0, 14'd1, 1'b0, "load_paused");
        chk3("load_cmd", cmd, 3'd5);
        chk1("load_idle_paused", paused, 1'b0);

        // Direction survives mode_down changes; start + load in PAUSED gives LOAD.
        press(3'b001, 1'b0, 14'd5, 1'b0, "run2");
        press(3'b001, 1'b0, 14'd5, 1'b0, "pause2");
        press(3'b001, 1'b1, 14'd5, 1'b0, "resume_md1");
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 14'd5, "dir_kept");
        chk3("dir_kept_cmd", cmd, 3'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 14'd6, "gap");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 14'd6, "gap");
        press(3'b001, 1'b0, 14'd6, 1'b0, "pause3");
        press(3'b101, 1'b0, 14'd6, 1'b0, "start_load");
        chk3("start_load_cmd", cmd, 3'd5);
        chk1("start_load_running", running, 1'b0);

        // Reset while INC is on the port.
        press(3'b001, 1'b0, 14'd7, 1'b0, "run4");
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 14'd7, "inc_before_rst");
        chk3("inc_before_rst_cmd", cmd, 3'd1);
        tick = 1'b0;
        rst = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        mdl_reset();

        rs = 1'b0; rc = 1'b0; rl = 1'b0; md_r = 1'b0;
        last_tick = 3;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0)  rs = ~rs;
            if ($urandom_range(0, 29) == 0) rc = ~rc;
            if ($urandom_range(0, 29) == 0) rl = ~rl;
            if ($urandom_range(0, 9) == 0)  md_r = ~md_r;
            last_tick++;
            tk = 1'b0;
            if (last_tick >= 3 && $urandom_range(0, 2) == 0) begin
                tk = 1'b1;
                last_tick = 0;
            end
            case ($urandom_range(0, 4))
                0:       cv = 14'd0;
                1:       cv = 14'd9999;
                2:       cv = 14'd1;
                3:       cv = 14'd9998;
                default: cv = 14'($urandom_range(0, 16383));
            endcase
            step(rs, rc, rl, tk, md_r, cv, "rand");
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        tick = 1'b0; btn_start = 1'b0; btn_clear = 1'b0; btn_load = 1'b0;
        mode_down = 1'b0; count = 14'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst = 1'b0;
`ifdef STOPWATCH_DEBOUNCE_EN
        run_debounce();
`else
        mdl_reset();
        run_main();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
